program_loader: RTL and testbench

//  Upstream stage of the 12-bit CPU: receives a byte stream (host/UART side), assembles
//  12-bit words and writes them into the 64x12 unified memory via a write port, then

---
 rtl/loader_pkg.sv | 27 ++
 rtl/loader_csum.sv | 23 ++
 rtl/program_loader.sv | 150 +++++++++++++++
 tb/tb_program_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants for the program loader: widths, frame header byte, FSM encodings
// and the memory write payload.
package loader_pkg;

   localparam int unsigned ADDR_W    = 6;
   localparam int unsigned DATA_W    = 12;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned CNT_W     = 7;
   localparam int unsigned MAX_WORDS = 64;

   localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_COUNT = 3'd2;
   localparam logic [2:0] ST_HI    = 3'd3;
   localparam logic [2:0] ST_LO    = 3'd4;
   localparam logic [2:0] ST_CSUM  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;
   localparam logic [2:0] ST_ERR   = 3'd7;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } mem_wr_t;

endpackage

// File: rtl/loader_csum.sv
// Running XOR of frame bytes; cleared when a new frame header is accepted.
module loader_csum
   import loader_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              upd,
   input  logic [BYTE_W-1:0] data,
   output logic [BYTE_W-1:0] sum
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (upd) begin
         sum <= sum ^ data;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Byte-stream frame loader: assembles 12-bit words into program memory, then starts the CPU.
// Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader
   import loader_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              cpu_start,
   output logic [ADDR_W-1:0] start_pc,
   output logic              error
);

   logic [2:0]        state, state_n;
   logic [ADDR_W-1:0] base_addr, base_n;
   logic [ADDR_W-1:0] cur_addr, cur_n;
   logic [CNT_W-1:0]  rem, rem_n;
   logic [3:0]        hi, hi_n;
   mem_wr_t           wr_q, wr_n;
   logic              we_n, ready_n, busy_n, start_n, error_n;
   logic [ADDR_W-1:0] pc_n;
   logic              accept;
   logic [2:0]        last_word_st;

   assign accept    = rx_valid && rx_ready;
   assign mem_addr  = wr_q.addr;
   assign mem_wdata = wr_q.data;

`ifdef LOADER_CHECKSUM_EN
   logic              csum_clr, csum_upd;
   logic [BYTE_W-1:0] csum;

   assign last_word_st = ST_CSUM;
   assign csum_clr = accept && (rx_data == SYNC_BYTE) && (state == ST_IDLE || state == ST_ERR);
   assign csum_upd = accept && (state == ST_ADDR || state == ST_COUNT ||
                                state == ST_HI   || state == ST_LO);

   loader_csum u_csum (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (csum_clr),
      .upd     (csum_upd),
      .data    (rx_data),
      .sum     (csum)
   );
`else
   assign last_word_st = ST_DONE;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_n = state;
      base_n  = base_addr;
      cur_n   = cur_addr;
      rem_n   = rem;
      hi_n    = hi;
      wr_n    = wr_q;
      we_n    = 1'b0;
      pc_n    = start_pc;
      case (state)
         ST_IDLE, ST_ERR: begin
            if (accept && rx_data == SYNC_BYTE) state_n = ST_ADDR;
         end
         ST_ADDR: begin
            if (accept) begin
               base_n  = rx_data[ADDR_W-1:0];
               cur_n   = rx_data[ADDR_W-1:0];
               state_n = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (accept) begin
               if (rx_data == 8'd0 || rx_data > BYTE_W'(MAX_WORDS)) begin
                  state_n = ST_ERR;
               end else begin
                  rem_n   = CNT_W'(rx_data);
                  state_n = ST_HI;
               end
            end
         end
         ST_HI: begin
            if (accept) begin
               hi_n    = rx_data[3:0];
               state_n = ST_LO;
            end
         end
         ST_LO: begin
            if (accept) begin
               we_n      = 1'b1;
               wr_n.addr = cur_addr;
               wr_n.data = {hi, rx_data};
               cur_n     = cur_addr + ADDR_W'(1);
               rem_n     = rem - CNT_W'(1);
               state_n   = (rem == CNT_W'(1)) ? last_word_st : ST_HI;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (accept) state_n = (rx_data == csum) ? ST_DONE : ST_ERR;
         end
`endif
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase

      ready_n = (state_n != ST_DONE);
      busy_n  = (state_n == ST_ADDR) || (state_n == ST_COUNT) || (state_n == ST_HI) ||
                (state_n == ST_LO)   || (state_n == ST_CSUM);
      start_n = (state_n == ST_DONE);
      error_n = (state_n == ST_ERR);
      if (state_n == ST_DONE) pc_n = base_n;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         base_addr <= '0;
         cur_addr  <= '0;
         rem       <= '0;
         hi        <= '0;
         wr_q      <= '0;
         mem_we    <= 1'b0;
         rx_ready  <= 1'b1;
         busy      <= 1'b0;
         cpu_start <= 1'b0;
         start_pc  <= '0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         base_addr <= base_n;
         cur_addr  <= cur_n;
         rem       <= rem_n;
         hi        <= hi_n;
         wr_q      <= wr_n;
         mem_we    <= we_n;
         rx_ready  <= ready_n;
         busy      <= busy_n;
         cpu_start <= start_n;
         start_pc  <= pc_n;
         error     <= error_n;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; define LOADER_CHECKSUM_EN here too to cover the checksum build.
module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [11:0] mem_wdata;
   logic        busy;
   logic        cpu_start;
   logic [5:0]  start_pc;
   logic        error;

   program_loader dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .cpu_start (cpu_start),
      .start_pc  (start_pc),
      .error     (error)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int wa[$];
   int wd[$];
   int n_start  = 0;
   int last_pc  = -1;
   logic [7:0] frm[$];
   int ea[$];
   int ed[$];

   // Record every write strobe and start pulse seen on the falling edge
   always @(negedge clock) begin
      if (mem_we) begin
         wa.push_back(int'(mem_addr));
         wd.push_back(int'(mem_wdata));
      end
      if (cpu_start) begin
         n_start = n_start + 1;
         last_pc = int'(start_pc);
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Called on a falling edge; returns on the falling edge after acceptance
   task automatic send(input logic [7:0] b, input int gap);
      int n;
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!rx_ready) begin
         check("rx_ready_timeout", 0, 1);
         rx_valid = 1'b0;
         return;
      end
      @(posedge clock);
      @(negedge clock);
      rx_valid = 1'b0;
      rx_data  = 8'hA5;
      repeat (gap) @(negedge clock);
   endtask

   task automatic send_frame(input int gap);
      foreach (frm[i]) send(frm[i], gap);
   endtask

   function automatic logic [7:0] frame_csum();
      logic [7:0] s;
      s = 8'h00;
      for (int i = 1; i < frm.size(); i++) s = s ^ frm[i];
      return s;
   endfunction

   task automatic check_writes(input string tag, input int base);
      check({tag, "_nwr"}, wa.size() - base, ea.size());
      for (int i = 0; i < ea.size(); i++) begin
         if (base + i < wa.size()) begin
            check($sformatf("%s_addr%0d", tag, i), wa[base+i], ea[i]);
            check($sformatf("%s_data%0d", tag, i), wd[base+i], ed[i]);
         end
      end
   endtask

   task automatic load_frame2();
      frm = '{8'hA5, 8'h0A, 8'h07, 8'h00, 8'h1F, 8'h08, 8'h20, 8'h04, 8'h1E,
              8'h00, 8'hA1, 8'h06, 8'hA2, 8'h0A, 8'h41, 8'h02, 8'h23};
      ea  = '{10, 11, 12, 13, 14, 15, 16};
      ed  = '{12'h01F, 12'h820, 12'h41E, 12'h0A1, 12'h6A2, 12'hA41, 12'h223};
   endtask

   initial begin
      int bw, bs;
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // 1: reset state
      check("rst_rx_ready", int'(rx_ready), 1);
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_mem_wdata", int'(mem_wdata), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cpu_start", int'(cpu_start), 0);
      check("rst_start_pc", int'(start_pc), 0);
      check("rst_error", int'(error), 0);

      // 2: basic load, preceded by a junk byte dropped in IDLE
      load_frame2();
      bw = wa.size(); bs = n_start;
      send(8'h33, 0);
      send(frm[0], 0);
      check("t2_busy_after_sync", int'(busy), 1);
      for (int i = 1; i < frm.size(); i++) send(frm[i], 0);
`ifdef LOADER_CHECKSUM_EN
      send(frame_csum(), 0);
`endif
      repeat (4) @(negedge clock);
      check_writes("t2", bw);
      check("t2_starts", n_start - bs, 1);
      check("t2_last_pc", last_pc, 10);
      check("t2_start_pc_hold", int'(start_pc), 10);
      check("t2_busy", int'(busy), 0);
      check("t2_error", int'(error), 0);

      // 3: address wrap 62,63,0; HI upper nibble ignored
      frm = '{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h23, 8'h02, 8'h34, 8'hF5, 8'h67};
`ifdef LOADER_CHECKSUM_EN
      frm.push_back(frame_csum());
`endif
      ea = '{62, 63, 0};
      ed = '{12'h123, 12'h234, 12'h567};
      bw = wa.size(); bs = n_start;
      send_frame(0);
      repeat (4) @(negedge clock);
      check_writes("t3", bw);
      check("t3_starts", n_start - bs, 1);
      check("t3_start_pc", int'(start_pc), 62);

      // 4: COUNT=0 and COUNT=65 both error; junk in ERR ignored; valid frame recovers
      bw = wa.size(); bs = n_start;
      frm = '{8'hA5, 8'h05, 8'h00};
      send_frame(0);
      repeat (2) @(negedge clock);
      check("t4_err_cnt0", int'(error), 1);
      check("t4_busy_cnt0", int'(busy), 0);
      send(8'h11, 0);
      repeat (2) @(negedge clock);
      check("t4_err_sticky", int'(error), 1);
      frm = '{8'hA5, 8'h05, 8'h41, 8'h01, 8'h02};
      send_frame(0);
      repeat (2) @(negedge clock);
      check("t4_err_cnt65", int'(error), 1);
      check("t4_nwr_err", wa.size() - bw, 0);
      check("t4_starts_err", n_start - bs, 0);
      check("t4_pc_kept", int'(start_pc), 62);
      frm = '{8'hA5, 8'h20, 8'h01, 8'h00, 8'hAB};
`ifdef LOADER_CHECKSUM_EN
      frm.push_back(frame_csum());
`endif
      ea = '{32};
      ed = '{12'h0AB};
      send_frame(0);
      repeat (4) @(negedge clock);
      check_writes("t4", bw);
      check("t4_error_clr", int'(error), 0);
      check("t4_starts", n_start - bs, 1);
      check("t4_start_pc", int'(start_pc), 32);

`ifdef LOADER_CHECKSUM_EN
      // 5: bad checksum keeps writes but errors; correct checksum starts
      load_frame2();
      check("t5_csum_const", int'(frame_csum()), 8'h4F);
      frm.push_back(frame_csum() ^ 8'h01);
      bw = wa.size(); bs = n_start;
      send_frame(0);
      repeat (4) @(negedge clock);
      check_writes("t5bad", bw);
      check("t5bad_error", int'(error), 1);
      check("t5bad_starts", n_start - bs, 0);
      check("t5bad_pc", int'(start_pc), 32);
      load_frame2();
      frm.push_back(frame_csum());
      bw = wa.size();
      send_frame(0);
      repeat (4) @(negedge clock);
      check_writes("t5ok", bw);
      check("t5ok_error", int'(error), 0);
      check("t5ok_starts", n_start - bs, 1);
      check("t5ok_pc", int'(start_pc), 10);
`endif

      // 6a: idle gaps between bytes (rx_data=A5 while invalid)
      load_frame2();
`ifdef LOADER_CHECKSUM_EN
      frm.push_back(frame_csum());
`endif
      bw = wa.size(); bs = n_start;
      send_frame(2);
      repeat (4) @(negedge clock);
      check_writes("t6a", bw);
      check("t6a_starts", n_start - bs, 1);
      check("t6a_pc", int'(start_pc), 10);

      // 6b: reset after the 3rd word aborts the frame
      frm = '{8'hA5, 8'h05, 8'h05, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
      ea = '{5, 6, 7};
      ed = '{12'h011, 12'h022, 12'h033};
      bw = wa.size(); bs = n_start;
      send_frame(0);
      @(negedge clock);
      check("t6b_busy_mid", int'(busy), 1);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      check("t6b_busy_rst", int'(busy), 0);
      send(8'h00, 0);
      send(8'h44, 0);
      send(8'h00, 0);
      send(8'h55, 0);
      repeat (4) @(negedge clock);
      check_writes("t6b", bw);
      check("t6b_starts", n_start - bs, 0);
      check("t6b_busy", int'(busy), 0);
      check("t6b_start_pc", int'(start_pc), 0);
      check("t6b_error", int'(error), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
